// File: rtl/axi_lite_loop_exdes.sv
// AXI4-Lite loopback example: generator -> monitor/scoreboard -> memoryless slave; optional SLV_READY_STALL_EN adds LFSR-gated slave READY/VALID.
// Write and read each take 3 cycles minimum; the generator keeps one transaction outstanding and holds each VALID until its handshake.
module axi_lite_loop_exdes #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          NUM_TXN   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic       aclk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] wr_count,
  output logic [7:0] rd_count,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_FINISH} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_TXN - 1);

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0] awaddr, araddr, txn_addr, exp_awaddr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_acc;

  // ---------------- generator ----------------
  assign txn_addr = ADDR_W'(BASE_ADDR) + ADDR_W'({idx_q, 2'b00});
  assign awaddr   = txn_addr;
  assign araddr   = txn_addr;
  assign wdata    = DATA_W'(SEED) ^ DATA_W'(idx_q);
  assign wstrb    = 4'hF;
  assign awvalid  = (state_q == S_WR_ADDR) && !aw_done_q;
  assign wvalid   = (state_q == S_WR_ADDR) && !w_done_q;
  assign bready   = (state_q == S_WR_RESP);
  assign arvalid  = (state_q == S_RD_ADDR);
  assign rready   = (state_q == S_RD_DATA);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_WR_ADDR;
        idx_d     = 8'd0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      S_WR_ADDR: begin
        // AW and W may complete in different cycles; advance once both have.
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = S_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WR_RESP: if (b_hs) begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'd0;
          state_d = S_RD_ADDR;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_WR_ADDR;
        end
      end
      S_RD_ADDR: if (ar_hs) state_d = S_RD_DATA;
      S_RD_DATA: if (r_hs) begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_RD_ADDR;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- slave ----------------
  logic        slv_gate;
  logic        wrdy_q, bvalid_q, wpend_q, arrdy_q, rvalid_q, rpend_q;
  logic [15:0] rd_addr_q;

`ifdef SLV_READY_STALL_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge aclk) begin
    if (reset) lfsr_q <= 8'h01;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign slv_gate = lfsr_q[0];
`else
  assign slv_gate = 1'b1;
`endif

  assign awready = wrdy_q;
  assign wready  = wrdy_q;
  assign wr_acc  = awvalid && wvalid && wrdy_q;
  assign bvalid  = bvalid_q;
  assign bresp   = 2'b00;
  assign arready = arrdy_q;
  assign rvalid  = rvalid_q;
  assign rresp   = 2'b00;
  assign rdata   = {rd_addr_q, ~rd_addr_q};

  always_ff @(posedge aclk) begin
    if (reset) begin
      wrdy_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      wpend_q   <= 1'b0;
      arrdy_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rpend_q   <= 1'b0;
      rd_addr_q <= 16'd0;
    end else begin
      wrdy_q  <= awvalid && wvalid && !wrdy_q && !bvalid_q && !wpend_q && slv_gate;
      // A response whose gate slot was missed waits in the pend flag.
      wpend_q <= (wr_acc || wpend_q) && !slv_gate;
      if (b_hs)                                bvalid_q <= 1'b0;
      else if ((wr_acc || wpend_q) && slv_gate) bvalid_q <= 1'b1;

      arrdy_q <= arvalid && !arrdy_q && !rvalid_q && !rpend_q && slv_gate;
      rpend_q <= (ar_hs || rpend_q) && !slv_gate;
      if (ar_hs) rd_addr_q <= araddr[15:0];
      if (r_hs)                                rvalid_q <= 1'b0;
      else if ((ar_hs || rpend_q) && slv_gate) rvalid_q <= 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0]  sb_widx_q, wr_cnt_q, rd_cnt_q, err_q;
  logic [15:0] sb_raddr_q;
  logic        pass_q, pass_now, err_now;

  assign exp_awaddr = ADDR_W'(BASE_ADDR) + ADDR_W'({sb_widx_q, 2'b00});
  assign err_now = (b_hs && bresp != 2'b00)
                || (r_hs && (rresp != 2'b00 || rdata != {sb_raddr_q, ~sb_raddr_q}))
                || (aw_hs && awaddr != exp_awaddr);
  assign pass_now = (err_q == 8'd0) && (wr_cnt_q == 8'(NUM_TXN)) && (rd_cnt_q == 8'(NUM_TXN));

  always_ff @(posedge aclk) begin
    if (reset) begin
      sb_widx_q  <= 8'd0;
      sb_raddr_q <= 16'd0;
      wr_cnt_q   <= 8'd0;
      rd_cnt_q   <= 8'd0;
      err_q      <= 8'd0;
      pass_q     <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      sb_widx_q <= 8'd0;
      wr_cnt_q  <= 8'd0;
      rd_cnt_q  <= 8'd0;
      err_q     <= 8'd0;
      pass_q    <= 1'b0;
    end else begin
      if (aw_hs) sb_widx_q <= sb_widx_q + 8'd1;
      if (ar_hs) sb_raddr_q <= araddr[15:0];
      if (b_hs)  wr_cnt_q <= wr_cnt_q + 8'd1;
      if (r_hs)  rd_cnt_q <= rd_cnt_q + 8'd1;
      if (err_now && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (state_q == S_FINISH) pass_q <= pass_now;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done      = (state_q == S_FINISH);
  assign pass      = (state_q == S_FINISH) ? pass_now : pass_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;
  assign err_count = err_q;

  // Write payload is discarded by the slave and only araddr[15:0] feeds the pattern.
  logic unused_ok;
  assign unused_ok = ^{wdata, wstrb, araddr};

endmodule

// File: tb/tb_axi_lite_loop_exdes.sv
// Directed bench for axi_lite_loop_exdes: reset, full run, NUM_TXN=1 instance, start-while-busy, reset mid-run.
module tb_axi_lite_loop_exdes;
  logic       aclk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, start1 = 1'b0;
  logic       busy, done, pass, busy1, done1, pass1;
  logic [7:0] wr_count, rd_count, err_count, wr1, rd1, err1;
  int         checks = 0, errors = 0;

  always #5 aclk = ~aclk;

  axi_lite_loop_exdes dut (
    .aclk(aclk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count));

  axi_lite_loop_exdes #(.NUM_TXN(1)) dut1 (
    .aclk(aclk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .wr_count(wr1), .rd_count(rd1), .err_count(err1));

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [9:0] bus_vr();
    return {dut.awvalid, dut.awready, dut.wvalid, dut.wready, dut.bvalid, dut.bready,
            dut.arvalid, dut.arready, dut.rvalid, dut.rready};
  endfunction

  // Pulses start on the main instance and runs until the first done pulse or the limit.
  task automatic run_main(input int limit, output int n, output int dones,
                          output logic [31:0] aw0, output logic [31:0] wd0, output logic [31:0] rd0);
    logic got_aw = 1'b0, got_r = 1'b0;
    aw0 = '0; wd0 = '0; rd0 = '0; dones = 0;
    start = 1'b1; tick; start = 1'b0; n = 1;
    while (n < limit && dones == 0) begin
      if (dut.awvalid && dut.awready && !got_aw) begin aw0 = dut.awaddr; wd0 = dut.wdata; got_aw = 1'b1; end
      if (dut.rvalid && dut.rready && !got_r) begin rd0 = dut.rdata; got_r = 1'b1; end
      if (done) dones++;
      else begin tick; n++; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; start1 = 1'b1;
    repeat (5) tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_held got %b exp 0", busy); end
    reset = 1'b0; start = 1'b0; start1 = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass); end
    checks++; if ({wr_count, rd_count, err_count} !== 24'd0)
      begin errors++; $display("FAIL reset_counts got %h exp 000000", {wr_count, rd_count, err_count}); end
    checks++; if (bus_vr() !== 10'd0) begin errors++; $display("FAIL reset_bus got %b exp 0", bus_vr()); end
    repeat (3) tick;
    checks++; if ({busy, busy1} !== 2'b00) begin errors++; $display("FAIL start_in_reset got %b exp 00", {busy, busy1}); end
  endtask

  task automatic test_full_run;
    int n, dones, extra;
    logic [31:0] aw0, wd0, rd0;
    run_main(2000, n, dones, aw0, wd0, rd0);
    checks++; if (dones !== 1) begin errors++; $display("FAIL run_done got %0d exp 1 (cycle budget)", dones); end
    checks++; if (aw0 !== 32'h0000_1000) begin errors++; $display("FAIL aw0_addr got %h exp 00001000", aw0); end
    checks++; if (wd0 !== 32'hA5A5_0000) begin errors++; $display("FAIL w0_data got %h exp a5a50000", wd0); end
    checks++; if (rd0 !== 32'h1000_EFFF) begin errors++; $display("FAIL r0_data got %h exp 1000efff", rd0); end
`ifdef SLV_READY_STALL_EN
    checks++; if (n <= 49) begin errors++; $display("FAIL stall_latency got %0d exp >49", n); end
`else
    checks++; if (n !== 49) begin errors++; $display("FAIL run_latency got %0d exp 49", n); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b exp 0", busy); end
    checks++; if (wr_count !== 8'd8) begin errors++; $display("FAIL wr_count got %0d exp 8", wr_count); end
    checks++; if (rd_count !== 8'd8) begin errors++; $display("FAIL rd_count got %0d exp 8", rd_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL err_count got %0d exp 0", err_count); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_at_done got %b exp 1", pass); end
    extra = 0;
    for (int k = 0; k < 20; k++) begin tick; if (done) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL done_single got %0d extra pulses exp 0", extra); end
    checks++; if ({pass, busy} !== 2'b10) begin errors++; $display("FAIL pass_held got %b exp 10", {pass, busy}); end
  endtask

  task automatic test_num_txn1;
    int n;
    start1 = 1'b1; tick; start1 = 1'b0; n = 1;
    while (!done1 && n < 500) begin tick; n++; end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL n1_done got %b exp 1 (cycle budget)", done1); end
`ifndef SLV_READY_STALL_EN
    checks++; if (n > 12) begin errors++; $display("FAIL n1_latency got %0d exp <=12", n); end
`endif
    checks++; if ({wr1, rd1, err1} !== 24'h010100)
      begin errors++; $display("FAIL n1_counts got %h exp 010100", {wr1, rd1, err1}); end
    checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL n1_pass got %b exp 1", pass1); end
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    start = 1'b1; tick; start = 1'b0;
    repeat (5) tick;
    start = 1'b1; tick; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_restart got %b exp 1", busy); end
    repeat (10) tick;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < 1500; k++) begin if (done) dones++; tick; end
    checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_done_pulses got %0d exp 1", dones); end
    checks++; if ({wr_count, rd_count} !== 16'h0808)
      begin errors++; $display("FAIL b2b_counts got %h exp 0808", {wr_count, rd_count}); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass got %b exp 1", pass); end
  endtask

  task automatic test_reset_mid_run;
    int n = 0, dones;
    logic [31:0] aw0, wd0, rd0;
    start = 1'b1; tick; start = 1'b0;
    while (!(dut.rready && rd_count == 8'd3) && n < 2000) begin tick; n++; end
    checks++; if (!(dut.rready && rd_count == 8'd3))
      begin errors++; $display("FAIL mid_reach_rd3 got rd_count %0d exp 3 (cycle budget)", rd_count); end
    reset = 1'b1; tick;
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags got %b exp 000", {busy, done, pass}); end
    checks++; if ({wr_count, rd_count, err_count} !== 24'd0)
      begin errors++; $display("FAIL mid_reset_counts got %h exp 000000", {wr_count, rd_count, err_count}); end
    checks++; if (bus_vr() !== 10'd0) begin errors++; $display("FAIL mid_reset_bus got %b exp 0", bus_vr()); end
    reset = 1'b0; tick;
    run_main(2000, n, dones, aw0, wd0, rd0);
    checks++; if (dones !== 1) begin errors++; $display("FAIL rerun_done got %0d exp 1 (cycle budget)", dones); end
    checks++; if ({wr_count, rd_count, err_count, 7'd0, pass} !== 32'h0808_0001)
      begin errors++; $display("FAIL rerun_result got %h exp 08080001", {wr_count, rd_count, err_count, 7'd0, pass}); end
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_num_txn1;
    test_back_to_back;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_loop_exdes.md
Name: axi_lite_loop_exdes

Overview:
- Self-contained AXI4-Lite example subsystem with three parts:
  - a runtime-master traffic generator;
  - a passthrough monitor/scoreboard on the internal bus;
  - a memoryless slave responder.
- On start, the generator issues NUM_TXN writes and then NUM_TXN reads.
- The monitor counts handshakes and checks every response against the slave's deterministic pattern.
- Used as the top-level example chip in simulation and as an on-chip bus smoke test.

Parameters:
- ADDR_W, 32, AXI address width (minimum 16).
- DATA_W, 32, AXI data width (fixed 32).
- NUM_TXN, 8, writes and reads per run (1..255).
- BASE_ADDR, 32'h0000_1000, address of transaction 0; transaction i uses BASE_ADDR + 4*i.
- SEED, 32'hA5A5_0000, write data seed.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; ignored unless idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last read completes.
- pass  out  1  valid from done onward; 1 iff err_count==0 and both counts equal NUM_TXN.
- wr_count  out  8  completed write transactions (B handshakes).
- rd_count  out  8  completed read transactions (R handshakes).
- err_count  out  8  scoreboard mismatches; saturates at 255.

Behaviour:
- Reset: busy=0, done=0, pass=0, all counts=0, all internal VALID/READY=0, master FSM=IDLE.
- Reset mid-run aborts immediately. No handshake completes in the reset cycle.
- Master FSM states: IDLE -> WR_ADDR -> WR_RESP -> (next i or RD_ADDR) -> RD_DATA -> (next i or FINISH) -> IDLE.
- IDLE: on start, clear the counts, set i=0, set busy=1.
- WR_ADDR: drive awvalid=wvalid=1 with:
  - awaddr = BASE_ADDR + 4*i;
  - wdata = SEED ^ i;
  - wstrb = 4'hF.
- Each VALID holds until its own handshake. Go to WR_RESP once both AW and W have handshaken (same or different cycles).
- WR_RESP: bready=1. On B handshake: i++, wr_count++. If i==NUM_TXN, reset i to 0 and go to RD_ADDR.
- RD_ADDR: arvalid=1 with araddr = BASE_ADDR + 4*i; on handshake go to RD_DATA.
- RD_DATA: rready=1. On R handshake: rd_count++, i++. If i==NUM_TXN, go to FINISH.
- FINISH: done=1 for one cycle, busy=0, latch pass, return to IDLE.
- Exactly one outstanding transaction at any time.
- Slave, no memory, write path:
  - awready and wready are registered.
  - Both assert together for one cycle, one cycle after awvalid and wvalid are both high and no B is pending.
  - bvalid is asserted the cycle after that handshake with bresp=OKAY (2'b00), held until bready.
  - Write data is discarded.
- Slave read path:
  - arready is registered and pulses one cycle after arvalid.
  - rvalid follows on the next cycle with rresp=OKAY and rdata = {araddr[15:0], ~araddr[15:0]}.
- Minimum latencies: write = 3 cycles from AW valid to B handshake; read = 3 cycles from AR valid to R handshake.
- Scoreboard (passthrough monitor): observes the bus only and never drives it. err_count increments on any of:
  - bresp != OKAY;
  - rresp != OKAY;
  - rdata != pattern of the captured araddr;
  - AW handshake whose awaddr differs from the expected address sequence.
- Counts wrap is impossible since NUM_TXN <= 255. err_count saturates at 255.
- start while busy is ignored. start in the same cycle as reset is ignored.

Optional Feature:
- SLV_READY_STALL_EN defined:
  - slave contains an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01, stepped every cycle);
  - each READY/VALID assertion by the slave is additionally gated so it occurs only in cycles where LFSR bit0=1.
  - Handshake rules stay AXI-legal: VALID, once asserted, is never withdrawn.
  - Counts and pass result are unchanged; only latency grows.
- SLV_READY_STALL_EN undefined: fixed latencies as above; no LFSR logic.

Test Plan:
- Reset held 5 cycles then released, no start -> busy=0, done=0, all counts 0, no VALID on the internal bus.
- start pulse, defaults -> 8 writes then 8 reads.
  - Transaction 0 address is 32'h1000 with data 32'hA5A5_0000.
  - Read 0 returns 32'h1000_EFFF.
  - done pulses once; wr_count=8, rd_count=8, err_count=0, pass=1.
- NUM_TXN=1 -> done within 12 cycles of start (no stall); pass=1.
- Second start pulse while busy -> ignored: counts still finish at 8 and 8, single done pulse.
- reset asserted during RD_DATA of read 3 -> next cycle all outputs at reset values; a new start completes the full run with pass=1.
- SLV_READY_STALL_EN defined -> run takes longer than without the feature, but wr_count=8, rd_count=8, err_count=0, pass=1.
